// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Handshaked data-memory bus between the load/store unit (master) and the
//   data memory (slave).
//   Request channel : bus_valid/bus_ready handshake carrying bus_we, bus_addr,
//                     bus_wstrb, bus_wdata.
//   Response channel: bus_rvalid qualifies bus_rdata (also acks stores).
interface load_store_unit_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Turns the RV32I datapath's memory request into one bus transaction with
//   byte strobes, stalls the core until the bus responds and returns the
//   size/sign-extended load value.
//   clk, reset (async, active-high)
//   MemReq_i, MemWrite_i, funct3_i, Addr_i, WriteData_i : core request
//   ReadData_o : extended load result (valid in DONE)
//   stall_o    : hold PC / suppress register write
//   fault_o    : illegal or misaligned access, dropped
//   bus        : master side of the data-memory bus
//
//   state | meaning
//   IDLE  | waiting for MemReq; legality check, request fields captured
//   REQ   | bus_valid high, fields held until bus_ready
//   WAIT  | request accepted, waiting for bus_rvalid
//   DONE  | result valid, core retires the instruction this edge
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        stall_o,
  output logic        fault_o,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;

  logic        legal;
  logic [3:0]  strb_new;
  logic [31:0] wdata_new;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    legal = 1'b1;
    if (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111) legal = 1'b0;
    if (funct3_i[1:0] == 2'b01 && Addr_i[0])                          legal = 1'b0;
    if (funct3_i == 3'b010 && Addr_i[1:0] != 2'b00)                    legal = 1'b0;
    // unsigned variants only exist for loads
    if (funct3_i[2] && MemWrite_i)                                     legal = 1'b0;
  end

  always_comb begin
    strb_new  = 4'b1111;
    wdata_new = WriteData_i;
    if (MemWrite_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          strb_new  = 4'b0001 << Addr_i[1:0];
          wdata_new = {4{WriteData_i[7:0]}};
        end
        2'b01: begin
          strb_new  = Addr_i[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{WriteData_i[15:0]}};
        end
        default: begin
          strb_new  = 4'b1111;
          wdata_new = WriteData_i;
        end
      endcase
    end
  end

  // lane selection uses the offset captured with the request
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = bus.bus_rdata[7:0];
      2'd1:    rd_byte = bus.bus_rdata[15:8];
      2'd2:    rd_byte = bus.bus_rdata[23:16];
      default: rd_byte = bus.bus_rdata[31:24];
    endcase
    rd_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'd0, rd_byte};
      3'b101:  rd_ext = {16'd0, rd_half};
      default: rd_ext = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    stall_o = 1'b0;
    fault_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemReq_i) begin
          if (legal) begin
            stall_o = 1'b1;
            we_d    = MemWrite_i;
            addr_d  = {Addr_i[31:2], 2'b00};
            strb_d  = strb_new;
            wdata_d = wdata_new;
            off_d   = Addr_i[1:0];
            f3_d    = funct3_i;
            state_d = REQ;
          end else begin
            fault_o = 1'b1;
            rdata_d = 32'd0;
          end
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus.bus_ready) state_d = WAIT;
      end
      WAIT: begin
        stall_o = 1'b1;
        if (bus.bus_rvalid) begin
          if (!we_q) rdata_d = rd_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        // a MemReq still high here belongs to the retiring instruction
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      strb_q  <= 4'd0;
      wdata_q <= 32'd0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
    end
  end

  // bus_valid decodes the state register so reset drops it immediately
  assign bus.bus_valid = (state_q == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = strb_q;
  assign bus.bus_wdata = wdata_q;
  assign ReadData_o    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        stall;
  logic        fault;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .MemReq_i    (mem_req),
    .MemWrite_i  (mem_write),
    .funct3_i    (funct3),
    .Addr_i      (addr),
    .WriteData_i (write_data),
    .ReadData_o  (read_data),
    .stall_o     (stall),
    .fault_o     (fault),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_rd = 32'd0;

  // observations recorded by drive_access
  bit          o_fault, o_first_stall, o_done, o_timeout, o_unstable, o_valid_seen, o_tail_busy;
  int          o_stalls;
  logic        o_we;
  logic [31:0] o_addr, o_wdata, o_rd, o_rd_tail;
  logic [3:0]  o_strb;

  // ---------------- reference model ----------------
  function automatic bit legal(bit we, logic [2:0] f3, logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    if (we && f3 >= 3'd4) return 1'b0;
    if ((f3 == 3'b001 || f3 == 3'b101) && (a % 2 != 0)) return 1'b0;
    if (f3 == 3'b010 && (a % 4 != 0)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int size_bytes(logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_strb(bit we, logic [2:0] f3, logic [31:0] a);
    logic [3:0] m;
    int n;
    if (!we) return 4'hF;
    n = size_bytes(f3);
    m = (n == 1) ? 4'b0001 : (n == 2) ? 4'b0011 : 4'b1111;
    return m << (a % 4);
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] wd);
    int n;
    n = size_bytes(f3);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int n;
    logic [31:0] v, mask;
    n = size_bytes(f3);
    if (n == 4) return rd;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (rd >> (8 * (a % 4))) & mask;
    if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- bus slave / core driver ----------------
  task automatic drive_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int rdy_dly, input int rv_dly, input bit spurious);
    int rq, wc;
    bit hs, rv, got;
    rq = 0; wc = 0; hs = 0; rv = 0; got = 0;
    o_fault = 0; o_first_stall = 0; o_done = 0; o_timeout = 0; o_unstable = 0;
    o_valid_seen = 0; o_tail_busy = 0; o_stalls = 0;
    o_we = 0; o_addr = 0; o_wdata = 0; o_strb = 0; o_rd = 0; o_rd_tail = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_write = we; funct3 = f3; addr = a; write_data = wd;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      #1;
      if (cyc == 0) o_first_stall = stall;
      if (stall) o_stalls++;
      if (bus.bus_valid) o_valid_seen = 1;
      if (fault) begin o_fault = 1; break; end
      if (rv && !stall) begin o_done = 1; o_rd = read_data; break; end
      bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = $urandom;
      if (bus.bus_valid) begin
        if (!got) begin
          got = 1; o_we = bus.bus_we; o_addr = bus.bus_addr;
          o_strb = bus.bus_wstrb; o_wdata = bus.bus_wdata;
        end else if (o_we !== bus.bus_we || o_addr !== bus.bus_addr ||
                     o_strb !== bus.bus_wstrb || o_wdata !== bus.bus_wdata) begin
          o_unstable = 1;
        end
        if (rq >= rdy_dly) begin
          bus.bus_ready = 1'b1; hs = 1;
        end else if (spurious) begin
          bus.bus_rvalid = 1'b1; bus.bus_rdata = ~rd;
        end
        rq++;
      end else if (hs && !rv) begin
        if (wc >= rv_dly) begin
          bus.bus_rvalid = 1'b1; bus.bus_rdata = rd; rv = 1;
        end
        wc++;
      end
      @(negedge clk);
    end
    if (!o_fault && !o_done) o_timeout = 1;
    @(negedge clk);
    mem_req = 1'b0; bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0;
    for (int t = 0; t < 2; t++) begin
      #1;
      if (t == 0) o_rd_tail = read_data;
      if (bus.bus_valid || stall || fault) o_tail_busy = 1;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; mem_req = 1'b0;
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (bus.bus_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.bus_valid); end
    n_cmp++; if (bus.bus_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus.bus_we); end
    n_cmp++; if (bus.bus_addr !== 32'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus.bus_addr); end
    n_cmp++; if (bus.bus_wstrb !== 4'd0) begin n_bad++; $display("FAIL rst_wstrb: got %b want 0", bus.bus_wstrb); end
    n_cmp++; if (bus.bus_wdata !== 32'd0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", bus.bus_wdata); end
    n_cmp++; if (read_data !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", read_data); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", fault); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    @(negedge clk); reset = 1'b0;
    model_rd = 32'd0;
  endtask

  task automatic test_load_word();
    drive_access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0, 1'b0);
    model_rd = 32'hDEADBEEF;
    n_cmp++; if (o_timeout || o_fault) begin n_bad++; $display("FAIL lw_complete: timeout %b fault %b want 0 0", o_timeout, o_fault); end
    n_cmp++; if (o_stalls !== 3) begin n_bad++; $display("FAIL lw_stall_cycles: got %0d want 3", o_stalls); end
    n_cmp++; if (o_addr !== 32'h100) begin n_bad++; $display("FAIL lw_addr: got %h want 00000100", o_addr); end
    n_cmp++; if (o_we !== 1'b0 || o_strb !== 4'b1111) begin n_bad++; $display("FAIL lw_we_strb: got %b/%b want 0/1111", o_we, o_strb); end
    n_cmp++; if (o_rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", o_rd); end
    n_cmp++; if (o_tail_busy) begin n_bad++; $display("FAIL lw_no_reissue: got busy want idle"); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] as  [3] = '{32'h203, 32'h203, 32'h202};
    logic [31:0] exs [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011};
    for (int i = 0; i < 3; i++) begin
      drive_access(1'b0, f3s[i], as[i], 32'd0, 32'h80112233, 0, 1, 1'b0);
      model_rd = exs[i];
      n_cmp++; if (o_rd !== exs[i]) begin n_bad++; $display("FAIL load_ext_%0d: got %h want %h", i, o_rd, exs[i]); end
      n_cmp++; if (o_addr !== 32'h200) begin n_bad++; $display("FAIL load_ext_addr_%0d: got %h want 00000200", i, o_addr); end
    end
  endtask

  task automatic test_store();
    drive_access(1'b1, 3'b000, 32'h7, 32'h000000A5, 32'h0BADF00D, 0, 0, 1'b0);
    n_cmp++; if (o_addr !== 32'h4) begin n_bad++; $display("FAIL sb_addr: got %h want 00000004", o_addr); end
    n_cmp++; if (o_we !== 1'b1) begin n_bad++; $display("FAIL sb_we: got %b want 1", o_we); end
    n_cmp++; if (o_strb !== 4'b1000) begin n_bad++; $display("FAIL sb_strb: got %b want 1000", o_strb); end
    n_cmp++; if (o_wdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o_wdata); end
    n_cmp++; if (o_rd !== model_rd) begin n_bad++; $display("FAIL sb_rdata_kept: got %h want %h", o_rd, model_rd); end
    drive_access(1'b1, 3'b001, 32'h2, 32'hCAFE1234, 32'd0, 0, 0, 1'b0);
    n_cmp++; if (o_strb !== 4'b1100) begin n_bad++; $display("FAIL sh_strb: got %b want 1100", o_strb); end
    n_cmp++; if (o_wdata !== 32'h12341234) begin n_bad++; $display("FAIL sh_wdata: got %h want 12341234", o_wdata); end
  endtask

  task automatic test_misaligned();
    drive_access(1'b0, 3'b010, 32'h102, 32'd0, 32'h55555555, 0, 0, 1'b0);
    model_rd = 32'd0;
    n_cmp++; if (o_fault !== 1'b1) begin n_bad++; $display("FAIL mis_fault: got %b want 1", o_fault); end
    n_cmp++; if (o_first_stall !== 1'b0) begin n_bad++; $display("FAIL mis_stall: got %b want 0", o_first_stall); end
    n_cmp++; if (o_valid_seen || o_tail_busy) begin n_bad++; $display("FAIL mis_no_bus: valid %b busy %b want 0 0", o_valid_seen, o_tail_busy); end
    n_cmp++; if (o_rd_tail !== 32'd0) begin n_bad++; $display("FAIL mis_rdata: got %h want 0", o_rd_tail); end
  endtask

  task automatic test_backpressure();
    drive_access(1'b0, 3'b001, 32'h3FE, 32'd0, 32'h7FFF1234, 5, 0, 1'b1);
    model_rd = 32'h00007FFF;
    n_cmp++; if (o_stalls !== 8) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d want 8", o_stalls); end
    n_cmp++; if (o_unstable) begin n_bad++; $display("FAIL bp_stable: got unstable want stable"); end
    n_cmp++; if (o_rd !== 32'h00007FFF) begin n_bad++; $display("FAIL bp_rdata: got %h want 00007fff", o_rd); end
  endtask

  task automatic test_reset_midflight();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      mem_req = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40;
      bus.bus_ready = 1'b1; bus.bus_rvalid = 1'b0;
      repeat (k) @(posedge clk);
      @(negedge clk); #1;
      n_cmp++; if (stall !== 1'b1 || bus.bus_valid !== (k == 1)) begin
        n_bad++; $display("FAIL midrst_pre_%0d: stall %b valid %b want 1 %b", k, stall, bus.bus_valid, (k == 1));
      end
      reset = 1'b1; mem_req = 1'b0; bus.bus_ready = 1'b0;
      #1;
      n_cmp++; if (stall !== 1'b0 || bus.bus_valid !== 1'b0) begin
        n_bad++; $display("FAIL midrst_drop_%0d: stall %b valid %b want 0 0", k, stall, bus.bus_valid);
      end
      @(negedge clk);
      reset = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'h12345678;
      @(negedge clk);
      bus.bus_rvalid = 1'b0;
      #1;
      model_rd = 32'd0;
      n_cmp++; if (stall !== 1'b0 || bus.bus_valid !== 1'b0 || read_data !== 32'd0) begin
        n_bad++; $display("FAIL midrst_late_rvalid_%0d: stall %b valid %b rdata %h want 0 0 0", k, stall, bus.bus_valid, read_data);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      bit we;
      logic [2:0] f3;
      logic [31:0] a, wd, rd;
      int d, r;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3 | (32'($urandom_range(0, 1)) << 1) & {30'd0, ~f3[1], 1'b0};
      wd = $urandom; rd = $urandom;
      d = $urandom_range(0, 3); r = $urandom_range(0, 3);
      drive_access(we, f3, a, wd, rd, d, r, 1'($urandom_range(0, 1)));
      if (legal(we, f3, a)) begin
        if (!we) model_rd = exp_load(f3, a, rd);
        n_cmp++; if (o_timeout || o_fault) begin n_bad++; $display("FAIL rnd_complete_%0d: timeout %b fault %b want 0 0", i, o_timeout, o_fault); end
        n_cmp++; if (o_stalls !== 3 + d + r) begin n_bad++; $display("FAIL rnd_stalls_%0d: got %0d want %0d", i, o_stalls, 3 + d + r); end
        n_cmp++; if (o_addr !== (a & ~32'h3) || o_we !== we) begin n_bad++; $display("FAIL rnd_addr_we_%0d: got %h/%b want %h/%b", i, o_addr, o_we, a & ~32'h3, we); end
        n_cmp++; if (o_strb !== exp_strb(we, f3, a)) begin n_bad++; $display("FAIL rnd_strb_%0d: got %b want %b", i, o_strb, exp_strb(we, f3, a)); end
        if (we) begin
          n_cmp++; if (o_wdata !== exp_wdata(f3, wd)) begin n_bad++; $display("FAIL rnd_wdata_%0d: got %h want %h", i, o_wdata, exp_wdata(f3, wd)); end
        end
        n_cmp++; if (o_unstable) begin n_bad++; $display("FAIL rnd_stable_%0d: got unstable want stable", i); end
        n_cmp++; if (o_rd !== model_rd) begin n_bad++; $display("FAIL rnd_rdata_%0d: got %h want %h", i, o_rd, model_rd); end
      end else begin
        model_rd = 32'd0;
        n_cmp++; if (!o_fault || o_first_stall || o_valid_seen) begin
          n_bad++; $display("FAIL rnd_illegal_%0d: fault %b stall %b valid %b want 1 0 0", i, o_fault, o_first_stall, o_valid_seen);
        end
        n_cmp++; if (o_rd_tail !== 32'd0) begin n_bad++; $display("FAIL rnd_illegal_rdata_%0d: got %h want 0", i, o_rd_tail); end
      end
      n_cmp++; if (o_tail_busy) begin n_bad++; $display("FAIL rnd_tail_%0d: got busy want idle", i); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bus_ready = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'd0;
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_misaligned();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
